// File: rtl/tmr_pkg.sv
// Shared definitions for the timer sequencer: register addresses, TCR/TSR
// bit positions, state encodings and a helper that builds TCR values.
package tmr_pkg;

   localparam logic [7:0] DEF_ADDR_TDR = 8'h00;
   localparam logic [7:0] DEF_ADDR_TCR = 8'h01;
   localparam logic [7:0] DEF_ADDR_TSR = 8'h02;

   localparam int TCR_LOAD   = 7;
   localparam int TCR_DW     = 5;
   localparam int TCR_EN     = 4;
   localparam int TCR_CLK_HI = 1;
   localparam int TCR_CLK_LO = 0;

   localparam int TSR_OVF = 0;
   localparam int TSR_UDF = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_TDR,
      S_W_LOAD,
      S_W_RUN,
      S_GAP,
      S_R_TSR,
      S_W_CLR,
      S_W_OFF
   } seq_state_t;

   typedef enum logic [1:0] {
      M_IDLE,
      M_SETUP,
      M_ACCESS
   } apb_state_t;

   // Reserved TCR bits (6, 3:2) are always written as zero.
   function automatic logic [7:0] tcr_value(input logic load, input logic en,
                                            input logic dw, input logic [1:0] clk_sel);
      logic [7:0] v;
      v = 8'h00;
      v[TCR_LOAD] = load;
      v[TCR_DW] = dw;
      v[TCR_EN] = en;
      v[TCR_CLK_HI:TCR_CLK_LO] = clk_sel;
      return v;
   endfunction

endpackage

// File: rtl/tmr_apb_if.sv
// APB bus between the sequencer (master) and the timer register block (slave).
interface tmr_apb_if;
   logic [7:0] paddr;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (output paddr, psel, penable, pwrite, pwdata,
                   input prdata, pready, pslverr);
   modport slave  (input paddr, psel, penable, pwrite, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/tmr_apb_master.sv
// Single-request APB master. A transfer is launched while req is high, and
// ack pulses for one cycle with rdata/slverr once the slave answers. The
// cycle in which ack is high never launches a new transfer, which guarantees
// an idle cycle (psel=0) between transfers while the requester updates req.
module tmr_apb_master
   import tmr_pkg::*;
(
   input  logic       pclk,
   input  logic       preset,
   input  logic       req,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       write,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       slverr,
   tmr_apb_if.master  apb
);

   apb_state_t mstate;

   // Setup/access sequencing; address, data and direction are captured at setup.
   always_ff @(posedge pclk) begin
      if (preset) begin
         mstate      <= M_IDLE;
         apb.paddr   <= 8'h00;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.pwdata  <= 8'h00;
         ack         <= 1'b0;
         rdata       <= 8'h00;
         slverr      <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (mstate)
            M_IDLE: begin
               if (req && !ack) begin
                  apb.psel   <= 1'b1;
                  apb.paddr  <= addr;
                  apb.pwrite <= write;
                  apb.pwdata <= wdata;
                  mstate     <= M_SETUP;
               end
            end
            M_SETUP: begin
               apb.penable <= 1'b1;
               mstate      <= M_ACCESS;
            end
            M_ACCESS: begin
               if (apb.pready) begin
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  ack         <= 1'b1;
                  rdata       <= apb.prdata;
                  slverr      <= apb.pslverr;
                  mstate      <= M_IDLE;
               end
            end
            default: mstate <= M_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/tmr_seq_ctrl.sv
// Timer sequencer: loads and starts the timer, polls TSR for the selected
// overflow/underflow flag, clears it, counts events and stops the timer
// after the configured number of periods or on request.
module tmr_seq_ctrl
   import tmr_pkg::*;
#(
   parameter logic [7:0] ADDR_TDR = DEF_ADDR_TDR,
   parameter logic [7:0] ADDR_TCR = DEF_ADDR_TCR,
   parameter logic [7:0] ADDR_TSR = DEF_ADDR_TSR,
   parameter int         POLL_GAP = 16
)
(
   input  logic       pclk,
   input  logic       preset,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] cfg_tdr,
   input  logic       cfg_dw,
   input  logic [1:0] cfg_clk_sel,
   input  logic [7:0] cfg_periods,
   tmr_apb_if.master  apb,
   output logic       busy,
   output logic       evt,
   output logic [7:0] evt_cnt,
   output logic       done,
   output logic       aborted,
   output logic       err
);

   seq_state_t  state;
   logic [7:0]  shd_tdr;
   logic        shd_dw;
   logic [1:0]  shd_clk;
   logic [7:0]  shd_periods;
   logic        stop_pend;
   logic        off_done;
   logic [15:0] gap_cnt;

   logic        req;
   logic [7:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        req_write;
   logic        ack;
   logic [7:0]  rdata;
   logic        slverr;
   logic        stop_any;
   logic        flag;
   logic [7:0]  cnt_next;

   assign stop_any = stop | stop_pend;
   assign flag     = |(rdata & (shd_dw ? (8'h01 << TSR_UDF) : (8'h01 << TSR_OVF)));
   assign cnt_next = evt_cnt + 8'd1;

   // Decode the APB request that belongs to the current sequencer state.
   always_comb begin
      req       = 1'b1;
      req_write = 1'b1;
      req_addr  = ADDR_TCR;
      req_wdata = 8'h00;
      case (state)
         S_W_TDR: begin
            req_addr  = ADDR_TDR;
            req_wdata = shd_tdr;
         end
         S_W_LOAD: req_wdata = tcr_value(1'b1, 1'b0, shd_dw, shd_clk);
         S_W_RUN:  req_wdata = tcr_value(1'b0, 1'b1, shd_dw, shd_clk);
         S_R_TSR: begin
            req_addr  = ADDR_TSR;
            req_write = 1'b0;
         end
         S_W_CLR:  req_addr  = ADDR_TSR;
         S_W_OFF:  req_wdata = tcr_value(1'b0, 1'b0, shd_dw, shd_clk);
         default:  req = 1'b0;
      endcase
   end

   tmr_apb_master u_apb (
      .pclk   (pclk),
      .preset (preset),
      .req    (req),
      .addr   (req_addr),
      .wdata  (req_wdata),
      .write  (req_write),
      .ack    (ack),
      .rdata  (rdata),
      .slverr (slverr),
      .apb    (apb)
   );

   // Sequencer FSM with gap/event counters and registered status pulses.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= S_IDLE;
         shd_tdr     <= 8'h00;
         shd_dw      <= 1'b0;
         shd_clk     <= 2'b00;
         shd_periods <= 8'h00;
         stop_pend   <= 1'b0;
         off_done    <= 1'b0;
         gap_cnt     <= 16'd0;
         busy        <= 1'b0;
         evt         <= 1'b0;
         evt_cnt     <= 8'h00;
         done        <= 1'b0;
         aborted     <= 1'b0;
         err         <= 1'b0;
      end else begin
         evt     <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         err     <= 1'b0;
         if (state != S_IDLE && stop) stop_pend <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  shd_tdr     <= cfg_tdr;
                  shd_dw      <= cfg_dw;
                  shd_clk     <= cfg_clk_sel;
                  shd_periods <= cfg_periods;
                  evt_cnt     <= 8'h00;
                  stop_pend   <= 1'b0;
                  off_done    <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_W_TDR;
               end
            end
            S_W_TDR, S_W_LOAD, S_W_RUN: begin
               if (ack) begin
                  if (slverr) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else if (stop_any) begin
                     off_done <= 1'b0;
                     state    <= S_W_OFF;
                  end else if (state == S_W_TDR) begin
                     state <= S_W_LOAD;
                  end else if (state == S_W_LOAD) begin
                     state <= S_W_RUN;
                  end else begin
                     gap_cnt <= 16'd0;
                     state   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (stop_any) begin
                  off_done <= 1'b0;
                  state    <= S_W_OFF;
               end else if (gap_cnt == 16'(POLL_GAP - 1)) begin
                  state <= S_R_TSR;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            S_R_TSR: begin
               if (ack) begin
                  if (slverr) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else if (stop_any) begin
                     off_done <= 1'b0;
                     state    <= S_W_OFF;
                  end else if (flag) begin
                     state <= S_W_CLR;
                  end else begin
                     gap_cnt <= 16'd0;
                     state   <= S_GAP;
                  end
               end
            end
            S_W_CLR: begin
               if (ack) begin
                  if (slverr) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     evt     <= 1'b1;
                     evt_cnt <= cnt_next;
                     if (shd_periods != 8'h00 && cnt_next == shd_periods) begin
                        off_done <= 1'b1;
                        state    <= S_W_OFF;
                     end else if (stop_any) begin
                        off_done <= 1'b0;
                        state    <= S_W_OFF;
                     end else begin
                        gap_cnt <= 16'd0;
                        state   <= S_GAP;
                     end
                  end
               end
            end
            S_W_OFF: begin
               if (ack) begin
                  if (slverr) begin
                     err <= 1'b1;
                  end else begin
                     done    <= off_done;
                     aborted <= !off_done;
                  end
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tmr_seq_ctrl.sv
// Scoreboard bench for tmr_seq_ctrl: directed sequences push the expected APB
// transfers and status pulses; a monitor pops and compares as they appear.
module tb_tmr_seq_ctrl;

   localparam int K_WR = 0;
   localparam int K_RD = 1;
   localparam int K_EVT = 2;
   localparam int K_DONE = 3;
   localparam int K_ABORT = 4;
   localparam int K_ERR = 5;

   typedef struct {
      int         kind;
      logic [7:0] addr;
      logic [7:0] data;
      int         len;
   } rec_t;

   logic       pclk = 1'b0;
   logic       preset;
   logic       start;
   logic       stop;
   logic [7:0] cfg_tdr;
   logic       cfg_dw;
   logic [1:0] cfg_clk_sel;
   logic [7:0] cfg_periods;
   logic       busy;
   logic       evt;
   logic [7:0] evt_cnt;
   logic       done;
   logic       aborted;
   logic       err;

   rec_t       expq[$];
   logic [7:0] rd_q[$];
   int compared = 0;
   int mismatched = 0;
   int xfer_idx = 0;
   int stall_idx = -1;
   int stall_wait = 0;
   int err_idx = -1;
   int acc = 0;
   int wait_now = 0;
   int run_len = 0;

   tmr_apb_if apb();

   tmr_seq_ctrl #(.POLL_GAP(16)) dut (
      .pclk        (pclk),
      .preset      (preset),
      .start       (start),
      .stop        (stop),
      .cfg_tdr     (cfg_tdr),
      .cfg_dw      (cfg_dw),
      .cfg_clk_sel (cfg_clk_sel),
      .cfg_periods (cfg_periods),
      .apb         (apb),
      .busy        (busy),
      .evt         (evt),
      .evt_cnt     (evt_cnt),
      .done        (done),
      .aborted     (aborted),
      .err         (err)
   );

   always #5 pclk = ~pclk;

   function automatic logic [31:0] packRec(input int kind, input logic [7:0] a,
                                           input logic [7:0] d, input int len);
      return {8'(kind), a, d, 8'(len)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic expRec(input int kind, input logic [7:0] a, input logic [7:0] d, input int len);
      rec_t r;
      r.kind = kind;
      r.addr = a;
      r.data = d;
      r.len = len;
      expq.push_back(r);
   endtask

   task automatic expWr(input logic [7:0] a, input logic [7:0] d, input int len = 1);
      expRec(K_WR, a, d, len);
   endtask

   task automatic expRd(input logic [7:0] d);
      rd_q.push_back(d);
      expRec(K_RD, 8'h02, d, 1);
   endtask

   task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d, input int len);
      rec_t e;
      if (expq.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL unexpected: actual %h required nothing", packRec(kind, a, d, len));
      end else begin
         e = expq.pop_front();
         checkOutput("scoreboard kind/addr/data/len", packRec(kind, a, d, len),
                     packRec(e.kind, e.addr, e.data, e.len));
      end
   endtask

   // Slave model: drives pready/prdata/pslverr shortly after each rising edge.
   always @(posedge pclk) begin
      #2;
      if (apb.psel && apb.penable) begin
         wait_now = (xfer_idx == stall_idx) ? stall_wait : 0;
         if (acc >= wait_now) begin
            apb.pready = 1'b1;
            apb.pslverr = (xfer_idx == err_idx);
            apb.prdata = (!apb.pwrite && rd_q.size() > 0) ? rd_q[0] : 8'h00;
         end else begin
            apb.pready = 1'b0;
            apb.pslverr = 1'b0;
         end
         acc++;
      end else begin
         apb.pready = 1'b0;
         apb.pslverr = 1'b0;
         apb.prdata = 8'h00;
         acc = 0;
      end
   end

   // Monitor: records completed transfers and status pulses on the falling edge.
   always @(negedge pclk) begin
      if (preset) begin
         run_len = 0;
      end else begin
         if (apb.psel && apb.penable) begin
            run_len++;
            if (apb.pready) begin
               observe(apb.pwrite ? K_WR : K_RD, apb.paddr,
                       apb.pwrite ? apb.pwdata : apb.prdata, run_len);
               if (!apb.pwrite && rd_q.size() > 0) void'(rd_q.pop_front());
               xfer_idx++;
               run_len = 0;
            end
         end else begin
            run_len = 0;
         end
         if (evt) observe(K_EVT, 8'h00, evt_cnt, 0);
         if (done) observe(K_DONE, 8'h00, 8'h00, 0);
         if (aborted) observe(K_ABORT, 8'h00, 8'h00, 0);
         if (err) observe(K_ERR, 8'h00, 8'h00, 0);
      end
   end

   task automatic applyStimulus(input logic [7:0] tdr, input logic dw,
                                input logic [1:0] clk_sel, input logic [7:0] periods);
      @(negedge pclk);
      cfg_tdr = tdr;
      cfg_dw = dw;
      cfg_clk_sel = clk_sel;
      cfg_periods = periods;
      start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((busy || expq.size() != 0) && n < 3000) begin
         @(negedge pclk);
         n++;
      end
      if (n >= 3000) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s timeout: busy %0d pending %0d required idle", name, busy, expq.size());
         expq.delete();
      end
      repeat (40) @(negedge pclk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      preset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      cfg_tdr = 8'h00;
      cfg_dw = 1'b0;
      cfg_clk_sel = 2'b00;
      cfg_periods = 8'h00;
      repeat (3) @(negedge pclk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset psel", 32'(apb.psel), 32'd0);
      checkOutput("reset evt_cnt", 32'(evt_cnt), 32'd0);
      checkOutput("reset done", 32'({done, aborted, err, evt}), 32'd0);
      preset = 1'b0;

      $display("[TB] count-down, one period");
      expWr(8'h00, 8'hFF);
      expWr(8'h01, 8'hA0);
      expWr(8'h01, 8'h30);
      expRd(8'h00);
      expRd(8'h01);
      expRd(8'h02);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h01, 0);
      expWr(8'h01, 8'h20);
      expRec(K_DONE, 8'h00, 8'h00, 0);
      applyStimulus(8'hFF, 1'b1, 2'd0, 8'd1);
      waitIdle("t1");
      checkOutput("t1 evt_cnt", 32'(evt_cnt), 32'd1);

      $display("[TB] count-up, three periods");
      expWr(8'h00, 8'hF0);
      expWr(8'h01, 8'h80);
      expWr(8'h01, 8'h10);
      expRd(8'h01);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h01, 0);
      expRd(8'h00);
      expRd(8'h02);
      expRd(8'h01);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h02, 0);
      expRd(8'h01);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h03, 0);
      expWr(8'h01, 8'h00);
      expRec(K_DONE, 8'h00, 8'h00, 0);
      applyStimulus(8'hF0, 1'b0, 2'd0, 8'd3);
      waitIdle("t2");
      checkOutput("t2 evt_cnt", 32'(evt_cnt), 32'd3);

      $display("[TB] stop during gap");
      expWr(8'h00, 8'h10);
      expWr(8'h01, 8'hA0);
      expWr(8'h01, 8'h30);
      expRd(8'h02);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h01, 0);
      expWr(8'h01, 8'h20);
      expRec(K_ABORT, 8'h00, 8'h00, 0);
      applyStimulus(8'h10, 1'b1, 2'd0, 8'd0);
      n = 0;
      while (!evt && n < 2000) begin
         @(negedge pclk);
         n++;
      end
      repeat (3) @(negedge pclk);
      stop = 1'b1;
      @(negedge pclk);
      stop = 1'b0;
      waitIdle("t3");
      checkOutput("t3 evt_cnt", 32'(evt_cnt), 32'd1);

      $display("[TB] slave error on load write");
      err_idx = xfer_idx + 1;
      stall_idx = xfer_idx + 1;
      stall_wait = 3;
      expWr(8'h00, 8'h77);
      expWr(8'h01, 8'hA2, 4);
      expRec(K_ERR, 8'h00, 8'h00, 0);
      applyStimulus(8'h77, 1'b1, 2'd2, 8'd2);
      waitIdle("t4");
      checkOutput("t4 evt_cnt", 32'(evt_cnt), 32'd0);
      err_idx = -1;
      stall_idx = -1;

      $display("[TB] reset during TSR read");
      stall_idx = xfer_idx + 3;
      stall_wait = 100;
      expWr(8'h00, 8'h00);
      expWr(8'h01, 8'h80);
      expWr(8'h01, 8'h10);
      applyStimulus(8'h00, 1'b0, 2'd0, 8'd0);
      n = 0;
      while (!(apb.psel && apb.penable && !apb.pwrite) && n < 500) begin
         @(negedge pclk);
         n++;
      end
      checkOutput("t5 reached read access", 32'(apb.psel && apb.penable && !apb.pwrite), 32'd1);
      preset = 1'b1;
      @(negedge pclk);
      checkOutput("t5 psel after reset", 32'(apb.psel), 32'd0);
      checkOutput("t5 penable after reset", 32'(apb.penable), 32'd0);
      checkOutput("t5 busy after reset", 32'(busy), 32'd0);
      preset = 1'b0;
      stall_idx = -1;
      checkOutput("t5 scoreboard drained", 32'(expq.size()), 32'd0);
      expWr(8'h00, 8'h33);
      expWr(8'h01, 8'hA1);
      expWr(8'h01, 8'h31);
      expRd(8'h02);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h01, 0);
      expWr(8'h01, 8'h21);
      expRec(K_DONE, 8'h00, 8'h00, 0);
      applyStimulus(8'h33, 1'b1, 2'd1, 8'd1);
      waitIdle("t5 restart");

      $display("[TB] start while busy");
      expWr(8'h00, 8'hAA);
      expWr(8'h01, 8'h83);
      expWr(8'h01, 8'h13);
      expRd(8'h01);
      expWr(8'h02, 8'h00);
      expRec(K_EVT, 8'h00, 8'h01, 0);
      expWr(8'h01, 8'h03);
      expRec(K_DONE, 8'h00, 8'h00, 0);
      applyStimulus(8'hAA, 1'b0, 2'd3, 8'd1);
      cfg_tdr = 8'h55;
      cfg_periods = 8'd0;
      cfg_dw = 1'b1;
      start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      waitIdle("t6");
      checkOutput("t6 evt_cnt", 32'(evt_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
